// File: rtl/id_ex_skid_stage.sv
// ID/EX pipeline stage with a valid/ready handshake on both sides and a 2-entry skid buffer.
// Optional performance counters (stall_count, bubble_count) are enabled by defining STAGE_PERF_COUNT_EN.
module id_ex_skid_stage #(
  parameter int CTRL_WIDTH  = 12,
  parameter int DATA_WIDTH  = 144,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_WIDTH-1:0]  in_ctrl,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_WIDTH-1:0]  out_ctrl,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [1:0]             occupancy
`ifdef STAGE_PERF_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0] stall_count,
  output logic [COUNT_WIDTH-1:0] bubble_count
`endif
);

  if (CTRL_WIDTH < 1 || DATA_WIDTH < 1 || COUNT_WIDTH < 1) begin : g_bad_params
    $error("id_ex_skid_stage: all widths must be at least 1");
  end

  // State bits are {skid_valid, main_valid}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_e;

  state_e                 state_q, state_d;
  logic                   main_valid, skid_valid;
  logic                   accept, drain;
  logic                   load_main_in, load_main_skid, load_skid;
  logic [CTRL_WIDTH-1:0]  main_ctrl, skid_ctrl;
  logic [DATA_WIDTH-1:0]  main_data, skid_data;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // State register: every update happens on the falling edge of clock.
  always_ff @(negedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) state_q <= EMPTY;
    else          state_q <= state_d;
  end

  // Next-state logic and datapath load enables.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            load_main_in = 1'b1;
            state_d      = ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_d   = FULL;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            load_main_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Output decode from the registered state only.
  always_comb begin
    main_valid = state_q[0];
    skid_valid = state_q[1];
    in_ready   = ~skid_valid;
    out_valid  = main_valid;
    out_ctrl   = main_valid ? main_ctrl : '0;
    out_data   = main_data;
    occupancy  = {1'b0, main_valid} + {1'b0, skid_valid};
  end

  // Entry storage. Flush zeroes control but deliberately keeps data untouched.
  always_ff @(negedge clock) begin
    // NOTE: the data registers are reset as well, so out_data reads zero straight after reset.
    if (!reset_n) begin
      main_ctrl <= '0;
      skid_ctrl <= '0;
      main_data <= '0;
      skid_data <= '0;
    end else if (flush) begin
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      if (load_main_in) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
        skid_ctrl <= '0;
      end
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end

`ifdef STAGE_PERF_COUNT_EN
  // Saturating counters; flush leaves them alone, only reset clears them.
  always_ff @(negedge clock) begin
    if (!reset_n) begin
      stall_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (out_valid && !out_ready && stall_count != '1)
        stall_count <= stall_count + COUNT_WIDTH'(1);
      if (!out_valid && out_ready && bubble_count != '1)
        bubble_count <= bubble_count + COUNT_WIDTH'(1);
    end
  end
`endif

endmodule
